// File: rtl/wordcount_pkg.sv
// wordcount_pkg: shared state encoding, command bit indices and chunk clamp helper
package wordcount_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_DRAIN, S_WR_ISSUE, S_WR_WAIT, S_FINISH
  } xfer_seq_state_t;
  localparam int CMD_RD_EN = 0;
  localparam int CMD_WR_EN = 1;
  function automatic logic [31:0] clamp_chunk(input logic [31:0] rem, input logic [31:0] cap);
    return rem > cap ? cap : rem;
  endfunction
endpackage

// File: rtl/wordcount_xfer_sequencer_if.sv
// wordcount_xfer_sequencer_if: ctrl_* handshake to one AXI master (start/addr/size out, done back)
interface wordcount_xfer_sequencer_if;
  logic        start;
  logic        done;
  logic [63:0] addr_offset;
  logic [63:0] xfer_size_in_bytes;
  modport master (output start, addr_offset, xfer_size_in_bytes, input done);
  modport slave  (input start, addr_offset, xfer_size_in_bytes, output done);
endinterface

// File: rtl/wordcount_xfer_sequencer_xfer_chunker.sv
// xfer_chunker: tracks total/done words, clamps chunks and registers the issued address and size
module xfer_chunker import wordcount_pkg::*; #(
  parameter int C_ADDR_WIDTH  = 64,
  parameter int C_WORD_BYTES  = 64,
  parameter int C_CHUNK_WORDS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    advance_i,
  input  logic                    issue_i,
  input  logic [31:0]             total_i,
  input  logic [C_ADDR_WIDTH-1:0] base_i,
  output logic                    last_o,
  output logic [C_ADDR_WIDTH-1:0] addr_o,
  output logic [C_ADDR_WIDTH-1:0] end_addr_o,
  output logic [63:0]             size_o
);
  localparam logic [31:0] CAP = 32'(C_CHUNK_WORDS);
  localparam logic [C_ADDR_WIDTH-1:0] WB = C_ADDR_WIDTH'(C_WORD_BYTES);
  logic [31:0] total_q, total_d, done_q, done_d, rem_q, rem_d;
  logic [C_ADDR_WIDTH-1:0] base_q, base_d, addr_q;
  logic [63:0] size_q;
  assign rem_q      = total_q - done_q;
  assign last_o     = rem_q <= CAP;
  assign total_d    = load_i ? total_i : total_q;
  assign base_d     = load_i ? base_i : base_q;
  assign done_d     = load_i ? '0 : advance_i ? done_q + clamp_chunk(rem_q, CAP) : done_q;
  assign rem_d      = total_d - done_d;
  assign end_addr_o = base_q + C_ADDR_WIDTH'(total_q) * WB;
  assign addr_o     = addr_q;
  assign size_o     = size_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
      done_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      total_q <= total_d;
      done_q  <= done_d;
      base_q  <= base_d;
      if (issue_i) begin
        addr_q <= base_d + C_ADDR_WIDTH'(done_d) * WB;
        size_q <= 64'(clamp_chunk(rem_d, CAP)) * 64'(C_WORD_BYTES);
      end
    end
  end
endmodule

// File: rtl/wordcount_xfer_sequencer.sv
// wordcount_xfer_sequencer: splits a job into bounded reads, drains, then bounded result writes
module wordcount_xfer_sequencer import wordcount_pkg::*; #(
  parameter int C_ADDR_WIDTH  = 64,
  parameter int C_WORD_BYTES  = 64,
  parameter int C_CHUNK_WORDS = 64
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic                       kick,
  input  logic [31:0]                command,
  input  logic [31:0]                num_of_words,
  input  logic [C_ADDR_WIDTH-1:0]    base_addr,
  input  logic [31:0]                result_words,
  input  logic                       core_idle,
  output logic                       busy,
  output logic                       job_done,
  wordcount_xfer_sequencer_if.master reader_ctrl,
  wordcount_xfer_sequencer_if.master writer_ctrl
);
  localparam logic [2:0] IDLE     = S_IDLE;
  localparam logic [2:0] RD_ISSUE = S_RD_ISSUE;
  localparam logic [2:0] RD_WAIT  = S_RD_WAIT;
  localparam logic [2:0] DRAIN    = S_DRAIN;
  localparam logic [2:0] WR_ISSUE = S_WR_ISSUE;
  localparam logic [2:0] WR_WAIT  = S_WR_WAIT;
  localparam logic [2:0] FINISH   = S_FINISH;
  logic [2:0] state_q, state_d;
  logic wr_en_q, rd_last, wr_last, unused_cmd;
  logic [C_ADDR_WIDTH-1:0] rd_addr, wr_addr, rd_end, unused_wr_end;
  logic [63:0] rd_size, wr_size;
  assign unused_cmd = ^command[31:2];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (kick) state_d = command[CMD_RD_EN] && num_of_words != 0 ? RD_ISSUE : DRAIN;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (reader_ctrl.done) state_d = rd_last ? DRAIN : RD_ISSUE;
      DRAIN:    if (core_idle) state_d = wr_en_q && result_words != 0 ? WR_ISSUE : FINISH;
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT:  if (writer_ctrl.done) state_d = wr_last ? FINISH : WR_ISSUE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && kick) wr_en_q <= command[CMD_WR_EN];
    end
  end
  assign busy                           = state_q != IDLE;
  assign job_done                       = state_q == FINISH;
  assign reader_ctrl.start              = state_q == RD_ISSUE;
  assign writer_ctrl.start              = state_q == WR_ISSUE;
  assign reader_ctrl.addr_offset        = 64'(rd_addr);
  assign writer_ctrl.addr_offset        = 64'(wr_addr);
  assign reader_ctrl.xfer_size_in_bytes = rd_size;
  assign writer_ctrl.xfer_size_in_bytes = wr_size;
  xfer_chunker #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH), .C_WORD_BYTES(C_WORD_BYTES), .C_CHUNK_WORDS(C_CHUNK_WORDS)
  ) u_rd (
    .clk(ap_clk), .rst(areset),
    .load_i(state_q == IDLE && kick),
    .advance_i(state_q == RD_WAIT && reader_ctrl.done),
    .issue_i(state_d == RD_ISSUE),
    .total_i(num_of_words), .base_i(base_addr),
    .last_o(rd_last), .addr_o(rd_addr), .end_addr_o(rd_end), .size_o(rd_size)
  );
  xfer_chunker #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH), .C_WORD_BYTES(C_WORD_BYTES), .C_CHUNK_WORDS(C_CHUNK_WORDS)
  ) u_wr (
    .clk(ap_clk), .rst(areset),
    .load_i(state_q == DRAIN && core_idle),
    .advance_i(state_q == WR_WAIT && writer_ctrl.done),
    .issue_i(state_d == WR_ISSUE),
    .total_i(result_words), .base_i(rd_end),
    .last_o(wr_last), .addr_o(wr_addr), .end_addr_o(unused_wr_end), .size_o(wr_size)
  );
endmodule

// File: doc/wordcount_xfer_sequencer.md
# wordcount_xfer_sequencer

Job-level DMA sequencer for the wordcount kernel. On a kick it splits the input word stream into bounded read transfers, issues them one at a time to the AXI read master, waits for the wordcount datapath to drain, then issues the result write-back to the AXI write master in bounded chunks. It sits between the kernel's ap_start/ap_done control logic and the read/write master `ctrl_*` ports, and owns all address and size arithmetic for a job.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, width of byte addresses.
- C_WORD_BYTES, 64, bytes per word (one 512-bit beat).
- C_CHUNK_WORDS, 64, maximum words per transfer (4096 B); power of two, ≥1.

Ports:
- ap_clk  in  1  kernel clock.
- areset  in  1  asynchronous, active-high reset.
- kick  in  1  job start pulse; ignored unless idle.
- command  in  32  bit0 = read-phase enable, bit1 = write-phase enable; other bits ignored.
- num_of_words  in  32  input words to read; sampled on accepted kick.
- base_addr  in  C_ADDR_WIDTH  input buffer byte address; sampled on accepted kick.
- result_words  in  32  words to write back; sampled on the cycle drain completes.
- core_idle  in  1  datapath has consumed all read data and holds final results.
- busy  out  1  job in progress.
- job_done  out  1  one-cycle pulse at job end.
- reader_ctrl_start  out  1  one-cycle start pulse to the read master.
- reader_ctrl_done  in  1  read master transfer-complete pulse.
- reader_ctrl_addr_offset  out  64  read byte address.
- reader_ctrl_xfer_size_in_bytes  out  64  read size in bytes.
- writer_ctrl_start, writer_ctrl_done, writer_ctrl_addr_offset, writer_ctrl_xfer_size_in_bytes: same as the reader_* ports, for the write master.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, DRAIN, WR_ISSUE, WR_WAIT, FINISH.
- IDLE: on kick, latch command, num_of_words and base_addr, and clear the counters.
  - Go to RD_ISSUE if cmd[0] and num_of_words≠0; otherwise go to DRAIN.
- RD_ISSUE (one cycle):
  - Set chunk = min(num_of_words − rd_done, C_CHUNK_WORDS).
  - Drive reader_ctrl_start=1, addr = base + rd_done·C_WORD_BYTES, size = chunk·C_WORD_BYTES.
  - Go to RD_WAIT.
- RD_WAIT:
  - On reader_ctrl_done: rd_done += chunk.
  - If rd_done = num_of_words, go to DRAIN; otherwise go to RD_ISSUE.
- DRAIN: wait for core_idle=1, then latch result_words.
  - Go to WR_ISSUE if cmd[1] and result_words≠0; otherwise go to FINISH.
- WR_ISSUE / WR_WAIT: mirror the read states.
  - Write addr = base + num_of_words·C_WORD_BYTES + wr_done·C_WORD_BYTES, so results land directly after the input.
- FINISH: pulse job_done for one cycle, then go to IDLE.
- Arithmetic:
  - Counters are 32 bits.
  - Address math is performed in C_ADDR_WIDTH bits and wraps modulo 2^C_ADDR_WIDTH.
  - Size is zero-extended to 64 bits.
- The addr and size outputs are registered and held stable from the start cycle until the next ISSUE state.
- A ctrl_done arriving outside the matching WAIT state is ignored.
- A kick while busy is ignored; the latched job parameters are unaffected.
- Reset mid-job: all state and outputs return to their reset values immediately. In-flight master transfers are not tracked; the masters share areset.

## Timing
- Reset values: busy=0, job_done=0, both ctrl_start=0, all addr and size outputs=0, state=IDLE.
- Kick sampled at cycle 0:
  - busy=1 from cycle 1.
  - First reader_ctrl_start at cycle 1 (RD_ISSUE), with addr and size valid in the same cycle.
- reader_ctrl_done at cycle N → next reader_ctrl_start at cycle N+1.
- core_idle high at cycle M in DRAIN → writer_ctrl_start at cycle M+1.
- The last writer_ctrl_done at cycle K → job_done=1 at cycle K+1, busy=0 at cycle K+2.
- busy = (state≠IDLE); job_done is high only in FINISH.
- A kick in the cycle after FINISH is accepted normally.
- ctrl_start is never asserted while the corresponding transfer is outstanding.

## Structure
- Shared package `wordcount_pkg`:
  - the state enum `xfer_seq_state_t`;
  - the command bit indices CMD_RD_EN=0 and CMD_WR_EN=1.
- One natural sub-module: `xfer_chunker`. It holds the total, the done counter and the chunk min/last-chunk compare, and is instantiated twice (read and write).

## Test plan
- num=130, C_CHUNK_WORDS=64, cmd=3, base=0x1000, result_words=2 → reads (0x1000, 4096), (0x2000, 4096), (0x3000, 128); then one write (0x3080, 128); then job_done.
- cmd=1, num=64 → exactly one read; after core_idle, no writer_ctrl_start; job_done one cycle after core_idle.
- num=0, cmd=3, result_words=0 → no starts issued; job_done follows core_idle; busy lasts exactly DRAIN+FINISH.
- Kick pulsed during RD_WAIT, plus a spurious writer_ctrl_done during RD_WAIT → no change in addresses, counts or sequencing.
- areset asserted in WR_WAIT → busy=0 and all outputs zero immediately; a fresh kick then restarts at base + 0.
- base=2^64−64, num=2 → second read addr wraps to 0x0.
